// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: IDLE -> LOAD -> WASH -> RINSE -> SPIN -> DONE -> IDLE.
// Latency: start accepted -> LOAD next clock; each phase lasts D*TICK_DIV clocks (1 clock if D=0).
// Backpressure: none; optional pause hold of the running phase when WASH_PAUSE_EN is defined.
module wash_cycle_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int MAX_LOAD = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic [4:0] wash_in,
  input  logic [4:0] rinse_in,
  input  logic [4:0] spin_in,
  input  logic [4:0] cloth_in,
  output logic       rd_en,
  output logic [1:0] mode_sel,
  output logic [2:0] phase,
  output logic [4:0] remaining,
  output logic       wash_on,
  output logic       rinse_on,
  output logic       spin_on,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

  state_t     state_q, state_d;
  logic [4:0] rem_q, rem_d;
  logic [7:0] presc_q, presc_d;
  logic [1:0] mode_sel_q, mode_sel_d;
  logic [4:0] rinse_q, rinse_d;
  logic [4:0] spin_q, spin_d;
  logic       err_q, err_d;

  logic       in_run;
  logic       pause_hold;
  logic       phase_end;
  logic       cloth_bad;

  assign in_run = (state_q == ST_WASH) || (state_q == ST_RINSE) || (state_q == ST_SPIN);

`ifdef WASH_PAUSE_EN
  assign pause_hold = pause && in_run;
`else
  // pause is accepted on the port but has no effect in this build
  logic pause_unused;
  assign pause_unused = pause;
  assign pause_hold   = 1'b0;
`endif

  // A zero-duration phase ends after its single clock; otherwise end on the last prescaler
  // clock of the final tick, i.e. the clock where remaining would reach 0.
  assign phase_end = (rem_q == 5'd0) || ((presc_q == PRESC_LAST) && (rem_q == 5'd1));

  // The load check uses the bank data present on the capture edge itself.
  assign cloth_bad = (cloth_in == 5'd0) || (32'(cloth_in) > MAX_LOAD);

  // Next-state logic: abort beats everything except reset, pause freezes run phases.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    presc_d    = presc_q;
    mode_sel_d = mode_sel_q;
    rinse_d    = rinse_q;
    spin_d     = spin_q;
    err_d      = err_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      rem_d   = 5'd0;
      presc_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d    = ST_LOAD;
            mode_sel_d = mode;
            err_d      = 1'b0;
          end
        end
        ST_LOAD: begin
          // Wash duration goes straight into remaining; later phases come from the captures.
          rinse_d = rinse_in;
          spin_d  = spin_in;
          presc_d = 8'd0;
          if (cloth_bad) begin
            state_d = ST_DONE;
            rem_d   = 5'd0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WASH;
            rem_d   = wash_in;
          end
        end
        ST_WASH, ST_RINSE, ST_SPIN: begin
          if (!pause_hold) begin
            if (phase_end) begin
              presc_d = 8'd0;
              case (state_q)
                ST_WASH: begin
                  state_d = ST_RINSE;
                  rem_d   = rinse_q;
                end
                ST_RINSE: begin
                  state_d = ST_SPIN;
                  rem_d   = spin_q;
                end
                default: begin
                  state_d = ST_DONE;
                  rem_d   = 5'd0;
                end
              endcase
            end else if (presc_q == PRESC_LAST) begin
              presc_d = 8'd0;
              rem_d   = rem_q - 5'd1;
            end else begin
              presc_d = presc_q + 8'd1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          rem_d   = 5'd0;
        end
        default: begin
          state_d = ST_IDLE;
          rem_d   = 5'd0;
          presc_d = 8'd0;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= 5'd0;
      presc_q    <= 8'd0;
      mode_sel_q <= 2'd0;
      rinse_q    <= 5'd0;
      spin_q     <= 5'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      presc_q    <= presc_d;
      mode_sel_q <= mode_sel_d;
      rinse_q    <= rinse_d;
      spin_q     <= spin_d;
      err_q      <= err_d;
    end
  end

  // Outputs decode the current state; actuators need a nonzero phase and no pause hold.
  always_comb begin
    phase     = state_q;
    remaining = rem_q;
    mode_sel  = mode_sel_q;
    err       = err_q;
    rd_en     = (state_q == ST_LOAD);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    wash_on   = (state_q == ST_WASH)  && (rem_q != 5'd0) && !pause_hold;
    rinse_on  = (state_q == ST_RINSE) && (rem_q != 5'd0) && !pause_hold;
    spin_on   = (state_q == ST_SPIN)  && (rem_q != 5'd0) && !pause_hold;
  end

endmodule

// File: doc/wash_cycle_ctrl.md
WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, clocks per duration tick (legal range 2..255).
REQ-002 SHALL have parameter MAX_LOAD, default 20, largest legal cloth load value.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; begin a cycle when sampled high in IDLE.
REQ-006 SHALL have port abort  input  1  level; cancel the current cycle.
REQ-007 SHALL have port pause  input  1  level; freeze the current phase (see Configuration).
REQ-008 SHALL have port mode  input  2  preset number to run, sampled with start.
REQ-009 SHALL have ports wash_in, rinse_in, spin_in, cloth_in  input  5 each  preset bank read data.
REQ-010 SHALL have port rd_en  output  1  read request to the preset bank (drives bank s0).
REQ-011 SHALL have port mode_sel  output  2  preset bank select (drives bank s1/s2).
REQ-012 SHALL have port phase  output  3  state: IDLE=0, LOAD=1, WASH=2, RINSE=3, SPIN=4, DONE=5.
REQ-013 SHALL have port remaining  output  5  ticks left in the current phase.
REQ-014 SHALL have ports wash_on, rinse_on, spin_on  output  1 each  actuator enables.
REQ-015 SHALL have ports busy, done, err  output  1 each  busy = phase not IDLE; done = 1-clock pulse; err = sticky fault flag.

Function
REQ-016 SHALL latch mode into mode_sel on the clock where IDLE sees start=1, and hold it until the next such clock.
REQ-017 SHALL start a cycle by moving IDLE->LOAD; start SHALL be ignored in every other state.
REQ-018 SHALL drive rd_en=1 only in LOAD, for exactly one clock, and capture wash_in/rinse_in/spin_in/cloth_in on that edge.
REQ-019 SHALL move LOAD->DONE with err=1 when the captured cloth is 0 or exceeds MAX_LOAD; otherwise LOAD->WASH.
REQ-020 SHALL sequence the phases WASH->RINSE->SPIN->DONE->IDLE, with DONE lasting one clock and done=1 only in that clock.
REQ-021 SHALL, on entering a phase, load remaining with that phase's captured duration D and clear the prescaler.
REQ-022 SHALL decrement remaining once every TICK_DIV clocks; a phase with D>0 SHALL last exactly D*TICK_DIV clocks and advance on the clock where remaining would reach 0.
REQ-023 SHALL give a phase with D=0 exactly one clock, with its actuator low and remaining=0.
REQ-024 SHALL assert wash_on only in WASH, rinse_on only in RINSE and spin_on only in SPIN, each only while D>0 and not paused; at most one actuator SHALL be high at any time.
REQ-025 SHALL, when abort=1 in any non-IDLE state, enter IDLE on the next clock: actuators low, remaining=0, no done pulse, err unchanged.
REQ-026 SHALL resolve simultaneous start and abort in IDLE by staying in IDLE (abort wins).
REQ-027 SHALL clear err on the clock where a new start is accepted.
REQ-028 SHALL force remaining=0 in IDLE, LOAD and DONE.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force on the next edge: phase=IDLE, remaining=0, prescaler=0, mode_sel=0, captured durations=0, and rd_en, wash_on, rinse_on, spin_on, busy, done and err all 0.
REQ-030 SHALL give rst priority over abort, pause and start, including when asserted mid-phase.

Configuration
REQ-031 SHALL, with macro WASH_PAUSE_EN defined, treat pause=1 in WASH/RINSE/SPIN as holding the state, remaining and prescaler with actuators low; normal operation SHALL resume from the held values when pause is released.
REQ-032 SHALL give abort priority over pause when WASH_PAUSE_EN is defined.
REQ-033 SHALL, without WASH_PAUSE_EN, keep the pause port but ignore it entirely.

Verification (TICK_DIV=4, MAX_LOAD=20)
REQ-034 SHALL check: mode=2, bank returns wash=3, rinse=2, spin=1, cloth=5, start pulse -> rd_en high for 1 clock with mode_sel=2; wash_on for 12 clocks, rinse_on for 8, spin_on for 4; then done high for 1 clock; busy low afterwards.
REQ-035 SHALL check: cloth=0 or cloth=21 -> LOAD->DONE, err=1, no actuator ever high; err clears on the next accepted start.
REQ-036 SHALL check: rinse=0 with wash=1, spin=1 -> RINSE lasts 1 clock with rinse_on=0; total from start to done = 1+4+1+4+1 clocks.
REQ-037 SHALL check: abort at clock 5 of WASH -> IDLE next clock, wash_on=0, no done; start and abort together in IDLE -> stays IDLE.
REQ-038 SHALL check, with WASH_PAUSE_EN: pause for 7 clocks mid-WASH (remaining=2) -> wash_on low and remaining held at 2, WASH lengthened by exactly 7 clocks; without the macro, the same stimulus leaves timing unchanged.
REQ-039 SHALL check: rst mid-SPIN -> all outputs at reset values next clock; a start issued afterwards runs a full cycle.
